dmem_pipe_ctrl: RTL
===================

# dmem_pipe_ctrl

Parametrised, pipelined data-memory controller between the load queue, the committed-store buffer and the data-memory port. It supports up to DEPTH outstanding memory transactions with in-order responses. It arbitrates loads against stores with a configurable priority and an anti-starvation limit. On a branch mispredict it squashes in-flight loads without disturbing committed stores, and it returns sign- or zero-extended load data and store completions to the ROB.

## Interface
Parameters:
- ROB_ID_W, 5, width of ROB tags.
- DEPTH, 4, maximum outstanding transactions (power of 2, ≥2).
- STORE_PRIO, 0, 0 = loads win ties, 1 = stores win ties.
- STARVE_LIMIT, 8, consecutive lost arbitrations after which the loser is forced to win.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  branch mispredict; squash all loads not yet written back.
- ld_valid  in  1  load request.
- ld_ready  out  1  load accepted when ld_valid && ld_ready.
- ld_rob_id  in  ROB_ID_W  load ROB tag.
- ld_addr  in  32  byte address.
- ld_funct3  in  3  lb/lh/lw/lbu/lhu encoding.
- st_valid  in  1  committed store request.
- st_ready  out  1  store accepted when st_valid && st_ready.
- st_rob_id  in  ROB_ID_W  store ROB tag.
- st_addr  in  32  byte address.
- st_wmask  in  4  byte enables, nonzero.
- st_wdata  in  32  pre-aligned write data.
- dmem_addr  out  32  word address ({addr[31:2],2'b00}).
- dmem_rmask  out  4  read enables; nonzero marks a load request.
- dmem_wmask  out  4  write enables; nonzero marks a store request.
- dmem_wdata  out  32  write data.
- dmem_ready  in  1  memory accepts the presented request this cycle.
- dmem_resp  in  1  in-order response for the oldest accepted request.
- dmem_rdata  in  32  read data, valid with dmem_resp.
- wb_valid  out  1  completion to ROB.
- wb_rob_id  out  ROB_ID_W  completing tag.
- wb_store  out  1  1 = store completion.
- wb_rd_data  out  32  extended load result; 0 for stores.
- wb_rdata_raw  out  32  raw dmem_rdata; 0 for stores.
- outstanding  out  $clog2(DEPTH+1)  tracker occupancy.
- resp_err  out  1  sticky; set on dmem_resp with empty tracker.

## Operation
- Issue slot: a single register drives dmem_*.
  - An empty slot drives both masks to 0.
  - The slot holds its request until dmem_ready.
- Tracker: FIFO of DEPTH entries {is_store, rob_id, funct3, addr[1:0], squashed}.
  - Push on the dmem handshake (slot valid && dmem_ready).
  - Pop on dmem_resp.
- Acceptance condition (both ld_ready and st_ready require it): the slot is empty or firing this cycle, and outstanding + slot_occupied_after < DEPTH.
- ld_ready is additionally forced to 0 while flush is high.
- Arbitration when both requests are valid:
  - The STORE_PRIO winner is granted.
  - A 4-bit-saturating starve counter increments each cycle the loser is valid and not granted.
  - When the counter reaches STARVE_LIMIT, the loser wins next and the counter clears.
  - The counter also clears whenever the loser is granted or deasserts valid.
- Flush:
  - Every tracker entry with is_store=0 gets squashed=1.
  - A load in the issue slot with dmem_ready=0 is cancelled (slot cleared).
  - A load in the issue slot with dmem_ready=1 is pushed with squashed=1.
  - Stores are never squashed or cancelled.
- Response handling: a popped entry with squashed=1 produces no writeback.
- Load extraction uses off=addr[1:0]:
  - lb: sign-extend byte[8*off+:8].
  - lbu: zero-extend byte[8*off+:8].
  - lh: sign-extend half[16*off[1]+:16].
  - lhu: zero-extend half[16*off[1]+:16].
  - lw: the full word.
  - Other funct3: 0.
- Address alias ordering between loads and stores is the LSQ's responsibility; this block preserves issue order only.

## Timing
- Reset (async): slot empty, tracker empty, starve counter 0, all outputs 0, resp_err 0.
- Load accepted in cycle N: dmem_* is valid in N+1.
  - With dmem_ready in N+1, the earliest dmem_resp is N+2.
  - wb_valid is registered and asserts in N+3.
- Throughput: one request per cycle while dmem_ready stays high and the tracker is not full.
- wb_* holds for exactly one cycle per non-squashed response.
- Tracker full (outstanding==DEPTH): ld_ready=st_ready=0. A dmem_resp pop in the same cycle reopens acceptance in that cycle.
- Simultaneous push and pop: occupancy is unchanged, and the FIFO pointers wrap modulo DEPTH.
- Flush and dmem_resp for a load head in the same cycle: the response is dropped.
- Flush in a cycle where wb_valid is already high: that output still completes.

## Test plan
- Single lw at addr 0x100, rob_id 3, rdata 0xDEADBEEF: dmem_rmask 4'hF in N+1; wb in N+3 with rob_id 3, wb_store 0, rd_data 0xDEADBEEF.
- lb at 0x103 with rdata 0x80FFFFFF, then lhu at 0x102 with rdata 0x80FF0000: rd_data 0xFFFFFF80, then 0x000080FF.
- Issue DEPTH loads while dmem_resp is held low: outstanding reaches 4 and ld_ready drops. One dmem_resp reopens ld_ready that cycle, and responses return in order.
- Two loads and one store outstanding, then pulse flush: only the store completes (wb_store 1). Both load responses are consumed with no wb, and outstanding returns to 0.
- STORE_PRIO=0, STARVE_LIMIT=8, ld_valid and st_valid held high: the store is granted on the 9th arbitration, then loads resume.
- dmem_resp with tracker empty: resp_err rises and stays high until rst, with no wb. Asserting rst mid-transaction clears all state immediately.

Source files
------------

// File: rtl/dmem_pipe_ctrl.sv
// Pipelined data-memory controller: one issue slot, an in-order response
// tracker, load/store arbitration with anti-starvation, and load squash.
module dmem_pipe_ctrl #(
    parameter int ROB_ID_W     = 5,
    parameter int DEPTH        = 4,
    parameter int STORE_PRIO   = 0,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [ROB_ID_W-1:0]        ld_rob_id,
    input  logic [31:0]                ld_addr,
    input  logic [2:0]                 ld_funct3,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [ROB_ID_W-1:0]        st_rob_id,
    input  logic [31:0]                st_addr,
    input  logic [3:0]                 st_wmask,
    input  logic [31:0]                st_wdata,
    output logic [31:0]                dmem_addr,
    output logic [3:0]                 dmem_rmask,
    output logic [3:0]                 dmem_wmask,
    output logic [31:0]                dmem_wdata,
    input  logic                       dmem_ready,
    input  logic                       dmem_resp,
    input  logic [31:0]                dmem_rdata,
    output logic                       wb_valid,
    output logic [ROB_ID_W-1:0]        wb_rob_id,
    output logic                       wb_store,
    output logic [31:0]                wb_rd_data,
    output logic [31:0]                wb_rdata_raw,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       resp_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [4:0] LIMIT = 5'(STARVE_LIMIT);
    localparam logic PRIO_ST = (STORE_PRIO != 0);

    // issue slot
    logic                slot_valid;
    logic                slot_store;
    logic [ROB_ID_W-1:0] slot_rob_id;
    logic [2:0]          slot_funct3;
    logic [31:0]         slot_addr;
    logic [3:0]          slot_wmask;
    logic [31:0]         slot_wdata;
    logic [3:0]          slot_rmask;

    // response tracker
    logic                trk_store  [DEPTH];
    logic [ROB_ID_W-1:0] trk_rob_id [DEPTH];
    logic [2:0]          trk_funct3 [DEPTH];
    logic [1:0]          trk_off    [DEPTH];
    logic                trk_squash [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_nxt;

    logic                push;
    logic                pop;
    logic                cancel;
    logic                slot_free;
    logic                can_accept;
    logic                ld_req;
    logic                ld_acc;
    logic                st_acc;
    logic                force_loser;
    logic                prio_st;
    logic                loser_valid;
    logic                loser_acc;
    logic [3:0]          starve_cnt;
    logic [3:0]          starve_nxt;

    logic                head_store;
    logic [ROB_ID_W-1:0] head_rob_id;
    logic [2:0]          head_funct3;
    logic [1:0]          head_off;
    logic                head_squash;
    logic                wb_fire;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [31:0]         ld_ext;

    assign push      = slot_valid & dmem_ready;
    assign pop       = dmem_resp & (count != '0);
    assign cancel    = slot_valid & ~slot_store & flush & ~dmem_ready;
    assign slot_free = ~slot_valid | push;
    assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    // room is reserved in the tracker for whatever sits in the slot
    assign can_accept = ~rst & slot_free & (count_nxt < CNT_W'(DEPTH));

    assign ld_req      = ld_valid & ~flush;
    assign force_loser = {1'b0, starve_cnt} >= LIMIT;
    assign prio_st     = PRIO_ST ^ force_loser;

    assign ld_ready = can_accept & ~flush & (~st_valid | ~prio_st);
    assign st_ready = can_accept & (~ld_req | prio_st);
    assign ld_acc   = ld_valid & ld_ready;
    assign st_acc   = st_valid & st_ready;

    assign loser_valid = PRIO_ST ? ld_valid : st_valid;
    assign loser_acc   = PRIO_ST ? ld_acc : st_acc;

    always_comb begin
        starve_nxt = starve_cnt;
        if (!loser_valid || loser_acc) begin
            starve_nxt = '0;
        end else if (starve_cnt != 4'hF) begin
            starve_nxt = starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid  <= 1'b0;
            slot_store  <= 1'b0;
            slot_rob_id <= '0;
            slot_funct3 <= '0;
            slot_addr   <= '0;
            slot_wmask  <= '0;
            slot_wdata  <= '0;
        end else if (ld_acc) begin
            slot_valid  <= 1'b1;
            slot_store  <= 1'b0;
            slot_rob_id <= ld_rob_id;
            slot_funct3 <= ld_funct3;
            slot_addr   <= ld_addr;
            slot_wmask  <= '0;
            slot_wdata  <= '0;
        end else if (st_acc) begin
            slot_valid  <= 1'b1;
            slot_store  <= 1'b1;
            slot_rob_id <= st_rob_id;
            slot_funct3 <= '0;
            slot_addr   <= st_addr;
            slot_wmask  <= st_wmask;
            slot_wdata  <= st_wdata;
        end else if (push || cancel) begin
            slot_valid  <= 1'b0;
        end
    end

    always_comb begin
        slot_rmask = 4'hF;
        case (slot_funct3)
            3'b000, 3'b100: slot_rmask = 4'b0001 << slot_addr[1:0];
            3'b001, 3'b101: slot_rmask = slot_addr[1] ? 4'b1100 : 4'b0011;
            default:        slot_rmask = 4'hF;
        endcase
    end

    assign dmem_addr  = {slot_addr[31:2], 2'b00};
    assign dmem_rmask = (slot_valid & ~slot_store) ? slot_rmask : 4'h0;
    assign dmem_wmask = (slot_valid & slot_store) ? slot_wmask : 4'h0;
    assign dmem_wdata = (slot_valid & slot_store) ? slot_wdata : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                trk_store[i]  <= 1'b0;
                trk_rob_id[i] <= '0;
                trk_funct3[i] <= '0;
                trk_off[i]    <= '0;
                trk_squash[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush && !trk_store[i]) begin
                    trk_squash[i] <= 1'b1;
                end
            end
            // a load leaving the slot during flush enters already squashed
            if (push) begin
                trk_store[wr_ptr]  <= slot_store;
                trk_rob_id[wr_ptr] <= slot_rob_id;
                trk_funct3[wr_ptr] <= slot_funct3;
                trk_off[wr_ptr]    <= slot_addr[1:0];
                trk_squash[wr_ptr] <= flush & ~slot_store;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
        end
    end

    assign outstanding = count;
    assign head_store  = trk_store[rd_ptr];
    assign head_rob_id = trk_rob_id[rd_ptr];
    assign head_funct3 = trk_funct3[rd_ptr];
    assign head_off    = trk_off[rd_ptr];
    assign head_squash = trk_squash[rd_ptr];

    always_comb begin
        byte_v = dmem_rdata[{head_off, 3'b000} +: 8];
        half_v = head_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (head_funct3)
            3'b000:  ld_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  ld_ext = {{16{half_v[15]}}, half_v};
            3'b010:  ld_ext = dmem_rdata;
            3'b100:  ld_ext = {24'h0, byte_v};
            3'b101:  ld_ext = {16'h0, half_v};
            default: ld_ext = 32'h0;
        endcase
    end

    // a flush arriving with the load response also drops it
    assign wb_fire = pop & (head_store | (~head_squash & ~flush));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_rob_id    <= '0;
            wb_store     <= 1'b0;
            wb_rd_data   <= '0;
            wb_rdata_raw <= '0;
            resp_err     <= 1'b0;
        end else begin
            wb_valid     <= wb_fire;
            wb_rob_id    <= wb_fire ? head_rob_id : '0;
            wb_store     <= wb_fire & head_store;
            wb_rd_data   <= (wb_fire & ~head_store) ? ld_ext : 32'h0;
            wb_rdata_raw <= (wb_fire & ~head_store) ? dmem_rdata : 32'h0;
            if (dmem_resp && count == '0) begin
                resp_err <= 1'b1;
            end
        end
    end

endmodule
